// File: rtl/free_list.sv
// free_list: 2-wide physical-register free list (circular tag FIFO); optional branch checkpoint under FREE_LIST_CKPT_EN.
// Latency: tags combinational from registered state in the request cycle; head/tail/count update on the next edge.
// Backpressure: alloc_stall when free tags < requested (all-or-nothing); reclaim never blocks, excess pushes dropped and flagged.
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

module free_list #(
    parameter int PHY_REGS  = 64,
    parameter int ARCH_REGS = 32,
    parameter int DEPTH     = PHY_REGS - ARCH_REGS,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_req_1,
    input  logic                    alloc_req_2,
    output logic [`PHY_REG_SEL-1:0] phy_dst_1_from_free_list,
    output logic [`PHY_REG_SEL-1:0] phy_dst_2_from_free_list,
    output logic                    alloc_stall,
    input  logic                    free_valid_1,
    input  logic [`PHY_REG_SEL-1:0] free_reg_1,
    input  logic                    free_valid_2,
    input  logic [`PHY_REG_SEL-1:0] free_reg_2,
`ifdef FREE_LIST_CKPT_EN
    input  logic                    ckpt_save,
    input  logic                    recover,
`endif
    output logic [PTR_W:0]          free_count,
    output logic                    overflow_err
);

    localparam int TAG_W = `PHY_REG_SEL;
    localparam int CNT_W = PTR_W + 1;

    // Pointers wrap by natural overflow, so DEPTH must be a power of two.
    logic [TAG_W-1:0] fifo [DEPTH];
    logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
    logic [PTR_W-1:0] head_next, tail_next, wr_idx_2;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] need, pops, room, pushes;
    logic             stall, acc_1, acc_2, drop;

`ifdef FREE_LIST_CKPT_EN
    logic [PTR_W-1:0] ckpt_head;
    logic [PTR_W-1:0] rec_gap;
`endif

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    assign phy_dst_1_from_free_list = fifo[head];
    assign phy_dst_2_from_free_list = alloc_req_1 ? fifo[head_p1] : fifo[head];

    assign alloc_stall  = stall;
    assign free_count   = count;

    always_comb begin
        need  = CNT_W'(alloc_req_1) + CNT_W'(alloc_req_2);
        stall = need > count;
`ifdef FREE_LIST_CKPT_EN
        stall = stall || recover;
`endif
        pops  = stall ? '0 : need;
        // Room left after this cycle's pops; slot 1 gets it before slot 2.
        room   = CNT_W'(DEPTH) - (count - pops);
        acc_1  = free_valid_1 && (room != '0);
        acc_2  = free_valid_2 && (room > CNT_W'(acc_1));
        drop   = (free_valid_1 && !acc_1) || (free_valid_2 && !acc_2);
        pushes = CNT_W'(acc_1) + CNT_W'(acc_2);

        wr_idx_2   = acc_1 ? tail_p1 : tail;
        tail_next  = tail + PTR_W'(pushes);
        head_next  = head + PTR_W'(pops);
        count_next = count - pops + pushes;
`ifdef FREE_LIST_CKPT_EN
        rec_gap = tail_next - ckpt_head;
        if (recover) begin
            head_next = ckpt_head;
            // Equal pointers are ambiguous: full if the list was full going in.
            if (rec_gap == '0 && (count + pushes) >= CNT_W'(DEPTH))
                count_next = CNT_W'(DEPTH);
            else
                count_next = CNT_W'(rec_gap);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= CNT_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            head         <= head_next;
            tail         <= tail_next;
            count        <= count_next;
            overflow_err <= overflow_err | drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= TAG_W'(ARCH_REGS + i);
        end else begin
            if (acc_1)
                fifo[tail] <= free_reg_1;
            if (acc_2)
                fifo[wr_idx_2] <= free_reg_2;
        end
    end

`ifdef FREE_LIST_CKPT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ckpt_head <= '0;
        else if (ckpt_save && !recover)
            ckpt_head <= head_next;
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: vector table through a scoreboard queue, plus reset and checkpoint sequences.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_1, alloc_req_2;
    logic [5:0] dst_1, dst_2;
    logic       alloc_stall;
    logic       free_valid_1, free_valid_2;
    logic [5:0] free_reg_1, free_reg_2;
    logic [5:0] free_count;
    logic       overflow_err;
`ifdef FREE_LIST_CKPT_EN
    logic       ckpt_save, recover;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk                      (clk),
        .reset                    (reset),
        .alloc_req_1              (alloc_req_1),
        .alloc_req_2              (alloc_req_2),
        .phy_dst_1_from_free_list (dst_1),
        .phy_dst_2_from_free_list (dst_2),
        .alloc_stall              (alloc_stall),
        .free_valid_1             (free_valid_1),
        .free_reg_1               (free_reg_1),
        .free_valid_2             (free_valid_2),
        .free_reg_2               (free_reg_2),
`ifdef FREE_LIST_CKPT_EN
        .ckpt_save                (ckpt_save),
        .recover                  (recover),
`endif
        .free_count               (free_count),
        .overflow_err             (overflow_err)
    );

    typedef struct {
        logic       r1, r2, fv1, fv2, ck, rc;
        logic [5:0] f1, f2;
        logic       e_stall;
        logic [5:0] e_d1, e_d2, e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r1, logic r2, logic fv1, logic [5:0] f1,
                                logic fv2, logic [5:0] f2, logic ck, logic rc,
                                logic es, logic [5:0] ed1, logic [5:0] ed2,
                                logic [5:0] ecnt, logic eovf);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.fv1 = fv1; v.f1 = f1; v.fv2 = fv2; v.f2 = f2;
        v.ck = ck; v.rc = rc; v.e_stall = es; v.e_d1 = ed1; v.e_d2 = ed2;
        v.e_cnt = ecnt; v.e_ovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_req_1 = 0; alloc_req_2 = 0;
        free_valid_1 = 0; free_valid_2 = 0;
        free_reg_1 = 0; free_reg_2 = 0;
`ifdef FREE_LIST_CKPT_EN
        ckpt_save = 0; recover = 0;
`endif
    endtask

    // Drive on negedge, check combinational outputs before the edge and state after it.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        alloc_req_1 = v.r1; alloc_req_2 = v.r2;
        free_valid_1 = v.fv1; free_reg_1 = v.f1;
        free_valid_2 = v.fv2; free_reg_2 = v.f2;
`ifdef FREE_LIST_CKPT_EN
        ckpt_save = v.ck; recover = v.rc;
`endif
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk({tag, " stall"}, int'(alloc_stall), int'(e.e_stall));
        if (!e.e_stall) begin
            chk({tag, " dst1"}, int'(dst_1), int'(e.e_d1));
            chk({tag, " dst2"}, int'(dst_2), int'(e.e_d2));
        end
        @(posedge clk);
        #1;
        chk({tag, " count"}, int'(free_count), int'(e.e_cnt));
        chk({tag, " ovf"}, int'(overflow_err), int'(e.e_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        #1;
        chk("rst count", int'(free_count), 32);
        chk("rst ovf", int'(overflow_err), 0);
        chk("rst dst1", int'(dst_1), 32);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset count", int'(free_count), 32);
        chk("reset ovf", int'(overflow_err), 0);
        chk("reset stall", int'(alloc_stall), 0);
        chk("reset dst1", int'(dst_1), 32);
        reset = 1;

        apply(mk(1,1, 0,0, 0,0, 0,0, 0, 32,33, 30, 0), "pair");

        // Reset mid-operation with requests in flight.
        @(negedge clk);
        alloc_req_1 = 1; alloc_req_2 = 1; free_valid_1 = 1; free_reg_1 = 9;
        #2;
        reset = 0;
        #1;
        chk("midrst count", int'(free_count), 32);
        chk("midrst dst1", int'(dst_1), 32);
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        chk("postrst count", int'(free_count), 32);

        // Main table: drain, empty stalls, no-bypass, refill, overflow.
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 0, 32,32, 31, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 33,34, 30, 0));
        for (int k = 0; k < 14; k++)
            tbl.push_back(mk(1,1, 0,0, 0,0, 0,0, 0, 6'(34+2*k), 6'(35+2*k), 6'(28-2*k), 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 62,63, 1, 0));
        tbl.push_back(mk(1,1, 0,0, 0,0, 0,0, 1, 0,0, 1, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 63,32, 0, 0));
        tbl.push_back(mk(1,0, 1,5, 0,0, 0,0, 1, 0,0, 1, 0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 5,33, 0, 0));
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,0, 1, 0,0, 0, 0));
        tbl.push_back(mk(0,0, 1,40, 1,41, 0,0, 0, 33,33, 2, 0));
        tbl.push_back(mk(1,0, 1,42, 0,0, 0,0, 0, 40,41, 2, 0));
        for (int k = 0; k < 15; k++)
            tbl.push_back(mk(0,0, 1,6'(10+2*k), 1,6'(11+2*k), 0,0, 0, 41,41, 6'(4+2*k), 0));
        tbl.push_back(mk(0,0, 1,7, 0,0, 0,0, 0, 41,41, 32, 1));
        tbl.push_back(mk(1,0, 1,8, 1,9, 0,0, 0, 41,42, 32, 1));
        tbl.push_back(mk(1,1, 0,0, 0,0, 0,0, 0, 42,10, 30, 1));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        do_reset();

`ifdef FREE_LIST_CKPT_EN
        apply(mk(1,1, 0,0, 0,0, 0,0, 0, 32,33, 30, 0), "ck pair");
        apply(mk(0,0, 0,0, 0,0, 1,0, 0, 34,34, 30, 0), "ck save");
        apply(mk(1,1, 0,0, 0,0, 0,0, 0, 34,35, 28, 0), "ck a1");
        apply(mk(1,1, 0,0, 0,0, 0,0, 0, 36,37, 26, 0), "ck a2");
        apply(mk(1,0, 0,0, 0,0, 0,1, 1, 0,0, 30, 0), "ck recover");
        apply(mk(1,1, 0,0, 0,0, 0,0, 0, 34,35, 28, 0), "ck after");
`endif

        @(negedge clk);
        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
